controle_botoes: RTL and testbench

- Upstream conditioning stage for the Frere Jacques player.
- Turns the two raw, bouncy, active-low board pushbuttons (play, stop) into clean registered control levels that drive the music sequencer's play and stop inputs.
- Per button: 2-FF synchronizer, debounce counter, press-edge detector. A 3-state transport FSM (IDLE/PLAYING/PAUSED) converts press pulses into levels.

---
 rtl/controle_botoes_pkg.sv | 14 +
 rtl/controle_botoes_if.sv | 23 ++
 rtl/debounce_botao.sv | 60 ++++++
 rtl/controle_botoes.sv | 70 +++++++
 tb/tb_controle_botoes.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/controle_botoes_pkg.sv
// Shared definitions for the pushbutton conditioning stage of the Frere Jacques player.
// Holds the transport state encoding and the debounce defaults.
package controle_botoes_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StPlaying = 2'b01,
        StPaused  = 2'b10
    } estado_e;

    localparam int unsigned DebounceCyclesDefault = 1000000;
    localparam int unsigned CntWDefault           = 20;

endpackage

// File: rtl/controle_botoes_if.sv
// Button-side and sequencer-side signals of the conditioning stage.
// The master drives the raw buttons; the slave (the DUT) drives the control levels.
interface controle_botoes_if;

    logic       btn_play_n;
    logic       btn_stop_n;
    logic       play;
    logic       stop;
    logic       play_pulse;
    logic       stop_pulse;
    logic [1:0] estado;

    modport master (
        output btn_play_n, btn_stop_n,
        input  play, stop, play_pulse, stop_pulse, estado
    );

    modport slave (
        input  btn_play_n, btn_stop_n,
        output play, stop, play_pulse, stop_pulse, estado
    );

endinterface

// File: rtl/debounce_botao.sv
// One active-low pushbutton: 2-FF synchronizer, debounce counter, stable level
// and a one-cycle strobe on each accepted released->pressed transition.
module debounce_botao
    import controle_botoes_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
    parameter int unsigned CNT_W           = CntWDefault
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_n_i,
    output logic pulse_o
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             stable_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    // Any agreeing cycle restarts the count, so short glitches never flip stable.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Strobe the cycle after stable has fallen.
    assign pulse_d = stable_dly_q & ~stable_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            stable_q     <= 1'b1;
            stable_dly_q <= 1'b1;
            cnt_q        <= '0;
            pulse_q      <= 1'b0;
        end else begin
            sync1_q      <= btn_n_i;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            pulse_q      <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/controle_botoes.sv
// Conditions the play/stop pushbuttons and runs the IDLE/PLAYING/PAUSED transport FSM
// whose registered levels drive the sequencer's play and stop inputs.
module controle_botoes
    import controle_botoes_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
    parameter int unsigned CNT_W           = CntWDefault
) (
    input  logic               Clk,
    input  logic               Reset_n,
    controle_botoes_if.slave   bus
);

    logic    play_pulse, stop_pulse;
    estado_e state_q, state_d;
    logic    play_q, stop_q;

    debounce_botao #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_play (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .btn_n_i (bus.btn_play_n),
        .pulse_o (play_pulse)
    );

    debounce_botao #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_stop (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .btn_n_i (bus.btn_stop_n),
        .pulse_o (stop_pulse)
    );

    // Stop has priority over a coincident play press.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (play_pulse) state_d = StPlaying;
            StPlaying: if (play_pulse) state_d = StPaused;
            StPaused:  if (play_pulse) state_d = StPlaying;
            default:   state_d = StIdle;
        endcase
        if (stop_pulse) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            play_q  <= 1'b0;
            stop_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            play_q  <= (state_d == StPlaying);
            stop_q  <= (state_d == StIdle);
        end
    end

    assign bus.play       = play_q;
    assign bus.stop       = stop_q;
    assign bus.play_pulse = play_pulse;
    assign bus.stop_pulse = stop_pulse;
    assign bus.estado     = state_q;

endmodule

// File: tb/tb_controle_botoes.sv
// Directed bench for controle_botoes with an 8-cycle debounce: timing, glitch
// rejection, transport sequence table, simultaneous presses and async reset.
module tb_controle_botoes;

    localparam int unsigned Deb = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    int   pp_cnt = 0;
    int   sp_cnt = 0;

    controle_botoes_if ifc ();

    controle_botoes #(
        .DEBOUNCE_CYCLES (Deb),
        .CNT_W           (4)
    ) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (ifc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ifc.play_pulse === 1'b1) pp_cnt++;
        if (ifc.stop_pulse === 1'b1) sp_cnt++;
    end

    typedef struct {
        bit   press_play;
        bit   press_stop;
        logic [1:0] estado;
        logic play;
        logic stop;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input bit p, input bit s);
        if (p) ifc.btn_play_n = 1'b0;
        if (s) ifc.btn_stop_n = 1'b0;
        tick(20);
        ifc.btn_play_n = 1'b1;
        ifc.btn_stop_n = 1'b1;
        tick(20);
    endtask

    task automatic check_outs(input string name, input logic [1:0] e, input logic p,
                              input logic s);
        check({name, ".estado"}, int'(ifc.estado), int'(e));
        check({name, ".play"}, int'(ifc.play), int'(p));
        check({name, ".stop"}, int'(ifc.stop), int'(s));
    endtask

    initial begin
        int pp0, sp0;
        vecs[0] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 2'b10, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0};

        ifc.btn_play_n = 1'b1;
        ifc.btn_stop_n = 1'b1;
        tick(3);
        check_outs("reset", 2'b00, 1'b0, 1'b1);
        check("reset.play_pulse", int'(ifc.play_pulse), 0);
        check("reset.stop_pulse", int'(ifc.stop_pulse), 0);
        rst_n = 1'b1;
        tick(2);

        // Clean press: pulse exactly at edge Deb+3, levels at Deb+4.
        pp0 = pp_cnt;
        ifc.btn_play_n = 1'b0;
        for (int k = 1; k <= int'(Deb) + 4; k++) begin
            tick(1);
            check($sformatf("clean.pulse@%0d", k), int'(ifc.play_pulse),
                  (k == int'(Deb) + 3) ? 1 : 0);
            if (k == int'(Deb) + 3) check("clean.play_early", int'(ifc.play), 0);
        end
        check_outs("clean", 2'b01, 1'b1, 1'b0);
        tick(30 - int'(Deb) - 4);
        ifc.btn_play_n = 1'b1;
        tick(25);
        check("clean.one_pulse", pp_cnt - pp0, 1);
        check_outs("clean.release", 2'b01, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle while PLAYING.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_outs("async_rst", 2'b00, 1'b0, 1'b1);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Bounce: 3-cycle toggles never debounce; final low edge gives one pulse.
        pp0 = pp_cnt;
        for (int i = 0; i < 10; i++) begin
            ifc.btn_play_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(3);
        end
        check("bounce.no_pulse", pp_cnt - pp0, 0);
        ifc.btn_play_n = 1'b0;
        for (int k = 1; k <= int'(Deb) + 4; k++) begin
            tick(1);
            if (k >= int'(Deb) + 2)
                check($sformatf("bounce.pulse@%0d", k), int'(ifc.play_pulse),
                      (k == int'(Deb) + 3) ? 1 : 0);
        end
        check("bounce.play", int'(ifc.play), 1);
        tick(20);
        ifc.btn_play_n = 1'b1;
        tick(20);
        check("bounce.one_pulse", pp_cnt - pp0, 1);

        // Glitch rejection on stop: Deb-1 low cycles ignored, Deb accepted.
        sp0 = sp_cnt;
        ifc.btn_stop_n = 1'b0;
        tick(Deb - 1);
        ifc.btn_stop_n = 1'b1;
        tick(20);
        check("glitch7.pulses", sp_cnt - sp0, 0);
        check_outs("glitch7", 2'b01, 1'b1, 1'b0);
        ifc.btn_stop_n = 1'b0;
        tick(Deb);
        ifc.btn_stop_n = 1'b1;
        tick(20);
        check("glitch8.pulses", sp_cnt - sp0, 1);
        check_outs("glitch8", 2'b00, 1'b0, 1'b1);

        // Transport sequence table, starting from IDLE.
        foreach (vecs[i]) begin
            pp0 = pp_cnt;
            sp0 = sp_cnt;
            press(vecs[i].press_play, vecs[i].press_stop);
            check_outs($sformatf("vec%0d", i), vecs[i].estado, vecs[i].play, vecs[i].stop);
            check($sformatf("vec%0d.pp", i), pp_cnt - pp0, int'(vecs[i].press_play));
            check($sformatf("vec%0d.sp", i), sp_cnt - sp0, int'(vecs[i].press_stop));
        end

        // Simultaneous presses from PAUSED: stop wins.
        press(1'b1, 1'b0);
        check_outs("pre_simul", 2'b10, 1'b0, 1'b0);
        ifc.btn_play_n = 1'b0;
        ifc.btn_stop_n = 1'b0;
        tick(Deb + 3);
        check("simul.play_pulse", int'(ifc.play_pulse), 1);
        check("simul.stop_pulse", int'(ifc.stop_pulse), 1);
        tick(1);
        check_outs("simul", 2'b00, 1'b0, 1'b1);
        ifc.btn_play_n = 1'b1;
        ifc.btn_stop_n = 1'b1;
        tick(20);
        check_outs("simul.release", 2'b00, 1'b0, 1'b1);

        // Reset mid-press: held button needs a fresh full debounce afterwards.
        ifc.btn_play_n = 1'b0;
        tick(5);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(int'(Deb) + 2);
        check("rst_press.no_pulse_yet", int'(ifc.play_pulse), 0);
        tick(2);
        check_outs("rst_press", 2'b01, 1'b1, 1'b0);
        ifc.btn_play_n = 1'b1;
        tick(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
